dsp_mem_wr_ctrl: RTL and testbench
==================================

Name: dsp_mem_wr_ctrl

Overview:
Write-side capture sequencer sitting directly upstream of the dsp_mem_bank chain, in the i_wclk domain. It takes the continuous deserialized ADC word stream, waits for an arm and trigger event plus a programmable post-trigger delay, then drives the bank chain's write-shift enable and data input for exactly the programmed number of words. It reports busy, done and progress back to scan/config.

Parameters:
- MemWidth, `MEM_WIDTH: data word width; matches bank i_dat_bank_mem.
- CntWidth, 16: width of the length and delay counters.

Ports:
- i_wclk  in  1  write clock; same clock as the bank write side.
- rst_sync_write  in  1  reset; asynchronous, active-high; clock i_wclk.
- i_arm  in  1  level; high enables capture, low aborts to IDLE.
- i_trig  in  1  trigger pulse or level; edge-detected internally.
- i_cfg_len  in  CntWidth  number of words to shift in; latched on arm.
- i_cfg_trig_dly  in  CntWidth  cycles from trigger to capture start; latched on arm.
- i_dat  in  MemWidth  ADC word stream; a new word every cycle.
- o_cfg_mode_wshift  out  1  to bank i_cfg_mode_wshift.
- o_dat_bank_mem  out  MemWidth  to first bank i_dat_bank_mem.
- o_busy  out  1  high in ARMED, DELAY, CAPTURE.
- o_done  out  1  sticky completion flag.
- o_word_cnt  out  CntWidth  words captured so far.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; latched cfg=0; trigger edge-detect flop=0.
- States: IDLE, ARMED, DELAY, CAPTURE, DONE.
  - IDLE: when i_arm=1, latch i_cfg_len and i_cfg_trig_dly, clear o_done and o_word_cnt, go to ARMED.
  - ARMED: on a rising edge of i_trig (i_trig=1 and previous i_trig=0):
    - dly=0: go to CAPTURE.
    - dly>0: load dly_cnt=dly and go to DELAY.
  - DELAY: decrement dly_cnt each cycle; go to CAPTURE in the cycle dly_cnt reaches 1. Triggers are ignored.
  - CAPTURE: increment o_word_cnt each cycle; go to DONE when o_word_cnt reaches len-1 (registered value). Triggers are ignored.
  - DONE: o_done=1; remain until i_arm=0, then go to IDLE with o_done still held. The next IDLE→ARMED transition clears o_done.
- len=0 latched: ARMED goes directly to DONE on trigger; o_cfg_mode_wshift is never asserted.
- i_arm=0 in ARMED, DELAY or CAPTURE: abort to IDLE next cycle.
  - o_cfg_mode_wshift drops one cycle later.
  - o_done stays 0; o_word_cnt holds the partial count.
- Datapath is exactly one register stage for both outputs:
  - o_dat_bank_mem <= i_dat every cycle, unconditionally.
  - o_cfg_mode_wshift <= (state==CAPTURE).
- Alignment: the bank adds one sync flop on wshift. Therefore:
  - Let D_k be the i_dat present in the k-th CAPTURE cycle, k=0..len-1.
  - The bank shifts D_k at the edge E0+k+2, where E0 is the edge entering CAPTURE.
  - Exactly len words are shifted; D_0 ends deepest in the chain.
- Latency:
  - Trigger edge sampled → first wshift high: dly+2 edges.
  - Last word shifted → o_done high: same edge.
- Trigger within 1 cycle of arm is valid.
- A trigger held high across arm does not fire; it must be a new rising edge.
- o_word_cnt saturates at len and does not wrap.

Decomposition:
- dsp_mem_pkg: wr_state_e enum (IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4); default CntWidth constant.
- One sub-module, dsp_mem_trig_edge: 1-flop rising-edge detector with asynchronous reset, reused by the read-side controller.
- Counters stay inline.

Test Plan:
- Basic capture: reset, arm, len=4, dly=0, trigger at cycle 10, i_dat=cycle index → wshift high 4 cycles; bank model shifts D_0..D_3 = 11..14; o_done=1 and o_word_cnt=4.
- Delay: len=2, dly=5 → first wshift at trigger+7 edges; captured words are trig+6 and trig+7.
- Abort: len=8; deassert i_arm after 3 CAPTURE cycles → wshift low from the next cycle onward; o_done=0; o_word_cnt=3; state IDLE.
- len=0 and stale trigger:
  - len=0 → no wshift, o_done=1.
  - i_trig held high before arm → no capture until it toggles low then high.
- Reset mid-CAPTURE: assert rst_sync_write asynchronously between edges → all outputs 0 immediately; state IDLE; re-arm captures normally.
- Full chain: len=NUM_BANKS*BANK_DEPTH with chained banks → last bank tail word = D_0 and first bank head word = D_{len-1}.

Source files
------------

// File: rtl/dsp_mem_pkg.sv
// Shared types and defaults for the dsp_mem write/read capture controllers.

package dsp_mem_pkg;

   localparam int unsigned DEF_MEM_WIDTH = 16;
   localparam int unsigned DEF_CNT_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      DELAY   = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } wr_state_e;

endpackage

// File: rtl/dsp_mem_trig_edge.sv
// Single-flop rising-edge detector; a level held high produces no further pulses.

module dsp_mem_trig_edge (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise_c
);

   logic sig_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig;
      end
   end

   assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/dsp_mem_wr_ctrl.sv
// Write-side capture sequencer: arm, trigger, post-trigger delay, then drives the
// bank chain write-shift enable and data for exactly the latched number of words.

module dsp_mem_wr_ctrl
   import dsp_mem_pkg::*;
#(
   parameter int unsigned MemWidth = DEF_MEM_WIDTH,
   parameter int unsigned CntWidth = DEF_CNT_WIDTH
) (
   input  logic                i_wclk,
   input  logic                rst_sync_write,
   input  logic                i_arm,
   input  logic                i_trig,
   input  logic [CntWidth-1:0] i_cfg_len,
   input  logic [CntWidth-1:0] i_cfg_trig_dly,
   input  logic [MemWidth-1:0] i_dat,
   output logic                o_cfg_mode_wshift,
   output logic [MemWidth-1:0] o_dat_bank_mem,
   output logic                o_busy,
   output logic                o_done,
   output logic [CntWidth-1:0] o_word_cnt
);

   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   wr_state_e           state;
   wr_state_e           state_nxt;
   logic                trig_rise_c;
   logic [CntWidth-1:0] len;
   logic [CntWidth-1:0] dly;
   logic [CntWidth-1:0] dly_cnt;
   logic [CntWidth-1:0] len_nxt;
   logic [CntWidth-1:0] dly_nxt;
   logic [CntWidth-1:0] dly_cnt_nxt;
   logic [CntWidth-1:0] word_cnt_nxt;
   logic                done_nxt;
   logic                busy_nxt;
   logic                wshift_nxt;

   dsp_mem_trig_edge u_trig_edge (
      .clk    (i_wclk),
      .rst    (rst_sync_write),
      .sig    (i_trig),
      .rise_c (trig_rise_c)
   );

   // State register
   always_ff @(posedge i_wclk or posedge rst_sync_write) begin
      if (rst_sync_write) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; dropping i_arm aborts any busy state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_arm) state_nxt = ARMED;
         end
         ARMED: begin
            if (!i_arm) begin
               state_nxt = IDLE;
            end else if (trig_rise_c) begin
               if (len == '0)      state_nxt = DONE;
               else if (dly == '0) state_nxt = CAPTURE;
               else                state_nxt = DELAY;
            end
         end
         DELAY: begin
            if (!i_arm)                state_nxt = IDLE;
            else if (dly_cnt == CntOne) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (!i_arm)                          state_nxt = IDLE;
            else if (o_word_cnt == len - CntOne) state_nxt = DONE;
         end
         DONE: begin
            if (!i_arm) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output/counter next values; config is latched on the IDLE->ARMED step
   always_comb begin
      len_nxt      = len;
      dly_nxt      = dly;
      dly_cnt_nxt  = dly_cnt;
      word_cnt_nxt = o_word_cnt;
      done_nxt     = o_done;
      case (state)
         IDLE: begin
            if (i_arm) begin
               len_nxt      = i_cfg_len;
               dly_nxt      = i_cfg_trig_dly;
               word_cnt_nxt = '0;
               done_nxt     = 1'b0;
            end
         end
         ARMED: begin
            if (i_arm && trig_rise_c) dly_cnt_nxt = dly;
         end
         DELAY: begin
            dly_cnt_nxt = dly_cnt - CntOne;
         end
         CAPTURE: begin
            if (i_arm && o_word_cnt != len) word_cnt_nxt = o_word_cnt + CntOne;
         end
         DONE: begin
            done_nxt = 1'b1;
         end
         default: begin
            done_nxt = o_done;
         end
      endcase
      wshift_nxt = (state == CAPTURE);
      busy_nxt   = (state_nxt inside {ARMED, DELAY, CAPTURE});
   end

   // Registered outputs, counters and one-stage data pipe to the bank
   always_ff @(posedge i_wclk or posedge rst_sync_write) begin
      if (rst_sync_write) begin
         len               <= '0;
         dly               <= '0;
         dly_cnt           <= '0;
         o_word_cnt        <= '0;
         o_done            <= 1'b0;
         o_busy            <= 1'b0;
         o_cfg_mode_wshift <= 1'b0;
         o_dat_bank_mem    <= '0;
      end else begin
         len               <= len_nxt;
         dly               <= dly_nxt;
         dly_cnt           <= dly_cnt_nxt;
         o_word_cnt        <= word_cnt_nxt;
         o_done            <= done_nxt;
         o_busy            <= busy_nxt;
         o_cfg_mode_wshift <= wshift_nxt;
         o_dat_bank_mem    <= i_dat;
      end
   end

endmodule

// File: tb/tb_dsp_mem_wr_ctrl.sv
// Directed bench for dsp_mem_wr_ctrl with a chained bank shift-register model.

module tb_dsp_mem_wr_ctrl;

   localparam int unsigned MW         = 16;
   localparam int unsigned CW         = 16;
   localparam int unsigned NUM_BANKS  = 2;
   localparam int unsigned BANK_DEPTH = 4;
   localparam int unsigned CHAIN      = NUM_BANKS * BANK_DEPTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm;
   logic          trig;
   logic [CW-1:0] cfg_len;
   logic [CW-1:0] cfg_dly;
   logic [MW-1:0] dat;
   logic          wshift;
   logic [MW-1:0] bank_dat;
   logic          busy;
   logic          done;
   logic [CW-1:0] word_cnt;

   int unsigned   cyc = 0;
   int unsigned   n_chk = 0;
   int unsigned   n_pass = 0;
   int unsigned   tc;

   logic          model_clr;
   logic [MW-1:0] chain [CHAIN];
   int unsigned   shift_cnt;
   int unsigned   first_edge;
   int unsigned   last_edge;
   int unsigned   done_edge;
   logic          done_prev;

   always #5 clk = ~clk;

   dsp_mem_wr_ctrl #(.MemWidth(MW), .CntWidth(CW)) dut (
      .i_wclk            (clk),
      .rst_sync_write    (rst),
      .i_arm             (arm),
      .i_trig            (trig),
      .i_cfg_len         (cfg_len),
      .i_cfg_trig_dly    (cfg_dly),
      .i_dat             (dat),
      .o_cfg_mode_wshift (wshift),
      .o_dat_bank_mem    (bank_dat),
      .o_busy            (busy),
      .o_done            (done),
      .o_word_cnt        (word_cnt)
   );

   // Bank chain model: chain[0] is the first bank head, chain[CHAIN-1] the last bank tail
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      done_prev <= done;
      if (model_clr) begin
         for (int i = 0; i < int'(CHAIN); i++) chain[i] <= '0;
         shift_cnt  <= 0;
         first_edge <= 0;
         last_edge  <= 0;
         done_edge  <= 0;
      end else begin
         if (wshift) begin
            chain[0] <= bank_dat;
            for (int i = 1; i < int'(CHAIN); i++) chain[i] <= chain[i-1];
            shift_cnt <= shift_cnt + 1;
            last_edge <= cyc + 1;
            if (shift_cnt == 0) first_edge <= cyc + 1;
         end
         if (done && !done_prev) done_edge <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      dat = MW'(cyc);
   endtask

   task automatic clr_model();
      model_clr = 1'b1;
      tick();
      model_clr = 1'b0;
   endtask

   task automatic arm_cfg(input int unsigned len, input int unsigned dly);
      cfg_len = CW'(len);
      cfg_dly = CW'(dly);
      arm     = 1'b1;
      tick();
   endtask

   task automatic fire();
      trig = 1'b1;
      tc   = cyc;
      tick();
      trig = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(done), 32'd1);
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; trig = 1'b0; cfg_len = '0; cfg_dly = '0;
      dat = '0; model_clr = 1'b1;
      tick(); tick(); tick();
      check("rst_wshift", 32'(wshift), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cnt", 32'(word_cnt), 32'd0);
      check("rst_dat", 32'(bank_dat), 32'd0);
      rst = 1'b0;
      model_clr = 1'b0;

      // Basic capture: len=4, dly=0, trigger in cycle 10 -> words 11..14
      clr_model();
      arm_cfg(4, 0);
      check("basic_busy", 32'(busy), 32'd1);
      while (cyc < 10) tick();
      fire();
      wait_done("basic_done", 20);
      check("basic_shifts", shift_cnt, 32'd4);
      check("basic_d3", 32'(chain[0]), 32'd14);
      check("basic_d2", 32'(chain[1]), 32'd13);
      check("basic_d1", 32'(chain[2]), 32'd12);
      check("basic_d0", 32'(chain[3]), 32'd11);
      check("basic_cnt", 32'(word_cnt), 32'd4);
      check("basic_first", first_edge, 32'd13);
      check("basic_done_edge", done_edge, last_edge);
      check("basic_busy_done", 32'(busy), 32'd0);
      arm = 1'b0;
      tick();
      check("basic_done_held", 32'(done), 32'd1);

      // Delay: len=2, dly=5, trigger in the first ARMED cycle
      clr_model();
      arm_cfg(2, 5);
      check("dly_done_clr", 32'(done), 32'd0);
      fire();
      wait_done("dly_done", 20);
      check("dly_first", first_edge, tc + 8);
      check("dly_w0", 32'(chain[1]), tc + 6);
      check("dly_w1", 32'(chain[0]), tc + 7);
      check("dly_shifts", shift_cnt, 32'd2);
      check("dly_done_edge", done_edge, last_edge);
      arm = 1'b0;
      tick();

      // Abort after three CAPTURE cycles
      clr_model();
      arm_cfg(8, 0);
      fire();
      tick(); tick(); tick();
      arm = 1'b0;
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_wshift_tail", 32'(wshift), 32'd1);
      tick();
      check("abort_wshift_low", 32'(wshift), 32'd0);
      tick(); tick(); tick();
      check("abort_shifts", shift_cnt, 32'd4);
      check("abort_cnt", 32'(word_cnt), 32'd3);
      check("abort_done", 32'(done), 32'd0);

      // len=0: straight to DONE, never shifts
      clr_model();
      arm_cfg(0, 0);
      fire();
      wait_done("len0_done", 10);
      check("len0_shifts", shift_cnt, 32'd0);
      check("len0_cnt", 32'(word_cnt), 32'd0);
      arm = 1'b0;
      tick();

      // Stale trigger held high across arm must not fire
      clr_model();
      trig = 1'b1;
      tick(); tick();
      arm_cfg(3, 0);
      tick(); tick(); tick(); tick();
      check("stale_shifts", shift_cnt, 32'd0);
      check("stale_busy", 32'(busy), 32'd1);
      check("stale_cnt", 32'(word_cnt), 32'd0);
      trig = 1'b0;
      tick();
      fire();
      wait_done("stale_done", 20);
      check("stale_shifts2", shift_cnt, 32'd3);
      check("stale_d0", 32'(chain[2]), tc + 1);
      arm = 1'b0;
      tick();

      // Asynchronous reset in the middle of CAPTURE
      clr_model();
      arm_cfg(6, 0);
      fire();
      tick(); tick();
      #2;
      rst = 1'b1;
      arm = 1'b0;
      #1;
      check("arst_wshift", 32'(wshift), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_cnt", 32'(word_cnt), 32'd0);
      check("arst_dat", 32'(bank_dat), 32'd0);
      tick();
      rst = 1'b0;
      clr_model();
      arm_cfg(2, 0);
      fire();
      wait_done("arst_rearm_done", 20);
      check("arst_rearm_shifts", shift_cnt, 32'd2);
      check("arst_rearm_cnt", 32'(word_cnt), 32'd2);
      arm = 1'b0;
      tick();

      // Full chain: len = NUM_BANKS*BANK_DEPTH
      clr_model();
      arm_cfg(CHAIN, 0);
      fire();
      wait_done("chain_done", 30);
      check("chain_shifts", shift_cnt, 32'(CHAIN));
      check("chain_cnt", 32'(word_cnt), 32'(CHAIN));
      check("chain_tail_d0", 32'(chain[CHAIN-1]), tc + 1);
      check("chain_head_dlast", 32'(chain[0]), tc + CHAIN);
      for (int k = 1; k < int'(CHAIN) - 1; k++)
         check("chain_mid", 32'(chain[CHAIN-1-k]), tc + 1 + 32'(k));
      arm = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
